dude_renderer: RTL and testbench

//  Downstream drawing stage of the game datapath: turns per-frame dude position updates into

---
 rtl/dude_renderer.sv | 202 ++++++++++++++++++++
 tb/tb_dude_renderer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dude_renderer.sv
// Drawing stage: erases the old sprite, then draws the new one, or clears the screen.
// Produces one registered pixel write per clock for the 160x120 frame-buffer adapter.
module dude_renderer #(
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned DUDE_W      = 4,
  parameter int unsigned DUDE_H      = 4,
  parameter logic [2:0]  DUDE_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       clear_req,
  input  logic [7:0] dude_x,
  input  logic [6:0] dude_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ERASE,
    S_DRAW
  } state_t;

  localparam logic [8:0] SW    = 9'(SCREEN_W);
  localparam logic [7:0] SH    = 8'(SCREEN_H);
  localparam logic [7:0] SW_M1 = 8'(SCREEN_W - 1);
  localparam logic [6:0] SH_M1 = 7'(SCREEN_H - 1);
  localparam logic [7:0] DW_M1 = 8'(DUDE_W - 1);
  localparam logic [6:0] DH_M1 = 7'(DUDE_H - 1);

  state_t     state_q, state_d;
  logic [7:0] px_q, px_d;
  logic [6:0] py_q, py_d;
  logic [7:0] old_x_q, old_x_d;
  logic [6:0] old_y_q, old_y_d;
  logic [7:0] new_x_q, new_x_d;
  logic [6:0] new_y_q, new_y_d;
  logic       old_valid_q, old_valid_d;
  logic       pend_q, pend_d;
  logic       fin_q, fin_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] col_q, col_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] pix_col;
  logic       row_end;
  logic       col_end;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  always_comb begin
    base_x  = 8'd0;
    base_y  = 7'd0;
    pix_col = BG_COLOUR;
    row_end = (px_q == DW_M1);
    col_end = (py_q == DH_M1);
    unique case (state_q)
      S_ERASE: begin
        base_x = old_x_q;
        base_y = old_y_q;
      end
      S_DRAW: begin
        base_x  = new_x_q;
        base_y  = new_y_q;
        pix_col = DUDE_COLOUR;
      end
      S_CLEAR: begin
        row_end = (px_q == SW_M1);
        col_end = (py_q == SH_M1);
      end
      default: ;
    endcase
    // Widened sums so off-screen pixels are masked, never wrapped
    sum_x = {1'b0, base_x} + {1'b0, px_q};
    sum_y = {1'b0, base_y} + {1'b0, py_q};
  end

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    old_x_d     = old_x_q;
    old_y_d     = old_y_q;
    new_x_d     = new_x_q;
    new_y_d     = new_y_q;
    old_valid_d = old_valid_q;
    pend_d      = pend_q;
    fin_d       = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    col_d       = col_q;
    plot_d      = 1'b0;
    done_d      = fin_q;
    ovr_d       = ovr_q;
    if (state_q == S_IDLE) begin
      if (clear_req || pend_q) begin
        state_d = S_CLEAR;
        pend_d  = 1'b0;
        if (frame_tick) ovr_d = 1'b1;
      end else if (frame_tick) begin
        new_x_d = dude_x;
        new_y_d = dude_y;
        state_d = old_valid_q ? S_ERASE : S_DRAW;
      end
    end else begin
      x_d    = sum_x[7:0];
      y_d    = sum_y[6:0];
      col_d  = pix_col;
      plot_d = (sum_x < SW) && (sum_y < SH);
      if (frame_tick) ovr_d  = 1'b1;
      if (clear_req)  pend_d = 1'b1;
      if (!row_end) begin
        px_d = px_q + 8'd1;
      end else begin
        px_d = 8'd0;
        py_d = col_end ? 7'd0 : py_q + 7'd1;
      end
      if (row_end && col_end) begin
        unique case (state_q)
          S_ERASE: state_d = S_DRAW;
          S_DRAW: begin
            state_d     = S_IDLE;
            old_x_d     = new_x_q;
            old_y_d     = new_y_q;
            old_valid_d = 1'b1;
            fin_d       = 1'b1;
          end
          default: begin
            state_d     = S_IDLE;
            old_valid_d = 1'b0;
            fin_d       = 1'b1;
          end
        endcase
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      old_x_q     <= '0;
      old_y_q     <= '0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      old_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      fin_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      old_x_q     <= old_x_d;
      old_y_q     <= old_y_d;
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
      old_valid_q <= old_valid_d;
      pend_q      <= pend_d;
      fin_q       <= fin_d;
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign vga_plot   = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_dude_renderer.sv
// Bench for dude_renderer: a queue of expected output beats, built from
// sprite/screen rectangles, is compared against the DUT every cycle.
module tb_dude_renderer;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int DW = 4;
  localparam int DH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] dude_x = '0;
  logic [6:0] dude_y = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;
  logic       overrun;

  always #5 clk = ~clk;

  dude_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .clear_req  (clear_req),
    .dude_x     (dude_x),
    .dude_y     (dude_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  typedef struct {
    bit         pix;
    bit         plot;
    bit         dn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } beat_t;

  beat_t q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  bit    m_ov = 0;
  bit    m_pend = 0;
  bit    m_ovr = 0;
  int    m_ox = 0;
  int    m_oy = 0;
  bit    e_plot, e_busy, e_done;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [2:0] e_c;
  bit    hold_ok = 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_rect(int bx, int by, int w, int h, logic [2:0] c);
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        beat_t b;
        int sx;
        int sy;
        sx = bx + k;
        sy = by + r;
        b.pix = 1;
        b.dn = 0;
        b.plot = (sx < SW) && (sy < SH);
        b.x = 8'(sx);
        b.y = 7'(sy);
        b.c = c;
        q.push_back(b);
      end
    end
  endtask

  task automatic push_done();
    beat_t d;
    d.pix = 0;
    d.plot = 0;
    d.dn = 1;
    d.x = '0;
    d.y = '0;
    d.c = '0;
    q.push_back(d);
  endtask

  task automatic model_edge(bit t, bit cl, int x, int y, bit r);
    bit idle;
    beat_t b;
    if (r) begin
      q.delete();
      m_ov = 0;
      m_pend = 0;
      m_ovr = 0;
      e_plot = 0;
      e_busy = 0;
      e_done = 0;
      e_x = '0;
      e_y = '0;
      e_c = '0;
      hold_ok = 1;
      return;
    end
    idle = (q.size() == 0) || (q.size() == 1 && q[0].dn);
    e_plot = 0;
    e_done = 0;
    if (q.size() > 0) begin
      b = q.pop_front();
      e_done = b.dn;
      if (b.pix) begin
        e_plot = b.plot;
        e_x = b.x;
        e_y = b.y;
        e_c = b.c;
        hold_ok = b.plot;
      end
    end
    if (idle) begin
      if (cl || m_pend) begin
        m_pend = 0;
        if (t) m_ovr = 1;
        push_rect(0, 0, SW, SH, 3'b000);
        push_done();
        m_ov = 0;
      end else if (t) begin
        if (m_ov) push_rect(m_ox, m_oy, DW, DH, 3'b000);
        push_rect(x, y, DW, DH, 3'b111);
        push_done();
        m_ox = x;
        m_oy = y;
        m_ov = 1;
      end
    end else begin
      if (t) m_ovr = 1;
      if (cl) m_pend = 1;
    end
    e_busy = (q.size() > 1) || (q.size() == 1 && !q[0].dn);
  endtask

  task automatic cyc(bit t, bit cl, logic [7:0] x, logic [6:0] y, bit r);
    frame_tick = t;
    clear_req = cl;
    dude_x = x;
    dude_y = y;
    reset = r;
    @(posedge clk);
    model_edge(t, cl, int'(x), int'(y), r);
    #1;
    chk("plot", vga_plot, e_plot);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("overrun", overrun, m_ovr);
    if (hold_ok) chk("xyc", {vga_x, vga_y, vga_colour}, {e_x, e_y, e_c});
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'd0, 7'd0, 0);
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      cyc(0, 0, 8'd0, 7'd0, 0);
      n++;
    end
    chk("wait_busy", busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit used_clr;
    used_clr = 0;
    cyc(0, 0, 8'd0, 7'd0, 1);
    cyc(0, 0, 8'd0, 7'd0, 1);
    idle_n(2);

    cyc(1, 0, 8'd10, 7'd20, 0);
    wait_idle(100);
    cyc(1, 0, 8'd11, 7'd20, 0);
    wait_idle(100);
    cyc(1, 0, 8'd158, 7'd118, 0);
    wait_idle(100);
    idle_n(1);

    cyc(1, 1, 8'd50, 7'd50, 0);
    wait_idle(20000);
    cyc(1, 0, 8'd30, 7'd40, 0);
    wait_idle(100);

    cyc(1, 0, 8'd60, 7'd70, 0);
    idle_n(20);
    cyc(1, 0, 8'd1, 7'd2, 0);
    wait_idle(100);
    cyc(1, 0, 8'd61, 7'd70, 0);
    idle_n(3);
    cyc(0, 1, 8'd0, 7'd0, 0);
    cyc(0, 1, 8'd0, 7'd0, 0);
    wait_idle(100);
    idle_n(1);
    wait_idle(20000);

    cyc(1, 0, 8'd90, 7'd90, 0);
    idle_n(21);
    cyc(0, 0, 8'd0, 7'd0, 1);
    cyc(1, 0, 8'd91, 7'd90, 0);
    wait_idle(100);

    for (int i = 0; i < 4000; i++) begin
      bit t;
      bit cl;
      bit r;
      t = ($urandom_range(0, 19) == 0);
      cl = !used_clr && ($urandom_range(0, 2999) == 0);
      r = ($urandom_range(0, 1999) == 0);
      if (cl) used_clr = 1;
      cyc(t, cl, 8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), r);
    end
    wait_idle(20000);
    idle_n(2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
